bsg_fifo_reorder_alloc_arbiter: RTL and testbench



---
 rtl/bsg_fifo_reorder_pkg.sv | 29 ++
 rtl/bsg_fifo_reorder_alloc_rr_pick.sv | 56 +++++
 rtl/bsg_fifo_reorder_alloc_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_bsg_fifo_reorder_alloc_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fifo_reorder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_fifo_reorder_pkg
//  Description : Shared types and width helpers for the reorder-FIFO
//                allocation arbiter.
//                  state_e         - arbiter FSM state encoding
//                  bsg_width       - bits needed to hold the value x
//                  bsg_safe_clog2  - ceil(log2(x)), never less than 1
//  Revision    : 1.0 - initial release
// ============================================================================
package bsg_fifo_reorder_pkg;

    typedef enum logic [0:0] {
        e_arb  = 1'b0,
        e_lock = 1'b1
    } state_e;

    // Number of bits needed to represent the value x itself (0..x).
    function automatic int bsg_width(input int x);
        return $clog2(x + 1);
    endfunction

    // Index width for x items; a single item still gets one bit.
    function automatic int bsg_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_fifo_reorder_alloc_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_fifo_reorder_alloc_rr_pick
//  Description : Combinational round-robin pick. Masks the eligibility vector
//                with the lock mask, then selects the first set candidate
//                scanning i_rr_ptr, i_rr_ptr+1, ... modulo reqs_p.
//  Ports       : i_elig       - per-requester eligibility
//                i_rr_ptr     - round-robin head index
//                i_lock_mask  - candidates allowed this cycle
//                o_grant_oh   - one-hot grant (all zero if none)
//                o_grant_idx  - index of the granted requester
//                o_grant_v    - a grant was made
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_fifo_reorder_alloc_rr_pick
    import bsg_fifo_reorder_pkg::*;
#(
    parameter int reqs_p = 4,
    localparam int c_LG_REQS = bsg_safe_clog2(reqs_p)
) (
    input  logic [reqs_p-1:0]    i_elig,
    input  logic [c_LG_REQS-1:0] i_rr_ptr,
    input  logic [reqs_p-1:0]    i_lock_mask,
    output logic [reqs_p-1:0]    o_grant_oh,
    output logic [c_LG_REQS-1:0] o_grant_idx,
    output logic                 o_grant_v
);

    logic [reqs_p-1:0]    w_cand;
    int                   w_scan;
    logic [c_LG_REQS-1:0] w_idx;

    always_comb begin
        w_cand      = i_elig & i_lock_mask;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_grant_v   = 1'b0;
        w_scan      = 0;
        w_idx       = '0;
        for (int off = 0; off < reqs_p; off++) begin
            // Explicit wrap so non-power-of-two requester counts rotate correctly.
            w_scan = int'(i_rr_ptr) + off;
            if (w_scan >= reqs_p) begin
                w_scan = w_scan - reqs_p;
            end
            w_idx = c_LG_REQS'(w_scan);
            if (!o_grant_v && w_cand[w_idx]) begin
                o_grant_v          = 1'b1;
                o_grant_idx        = w_idx;
                o_grant_oh[w_idx]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bsg_fifo_reorder_alloc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_fifo_reorder_alloc_arbiter
//  Description : Shares the variable-allocation port of a reorder FIFO among
//                reqs_p requesters. One grant per cycle, round-robin, with a
//                starvation lock that reserves the port for a head requester
//                that has been blocked by lack of space for too long.
//  Ports       : clk_i, reset_i              - clock, sync active-high reset
//                req_v_i / req_amount_i      - per-requester request + size
//                req_yumi_o                  - one-hot grant
//                grant_id_o                  - base slot id (= fifo_alloc_id_i)
//                fifo_alloc_v_count_i        - free entries in the FIFO
//                fifo_alloc_id_i             - FIFO write-pointer base id
//                fifo_alloc_yumi_variable_o  - amount allocated this cycle
//                locked_o                    - starvation lock active
//  Option      : BSG_FIFO_REORDER_ALLOC_ARBITER_STATS_EN adds saturating
//                stat_grants_o, stat_slots_o and stat_locks_o counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_fifo_reorder_alloc_arbiter
    import bsg_fifo_reorder_pkg::*;
#(
    parameter int reqs_p         = 4,
    parameter int els_p          = 16,
    parameter int starve_limit_p = 8,
    localparam int c_CNT_W   = bsg_width(els_p),
    localparam int c_LG_ELS  = bsg_safe_clog2(els_p),
    localparam int c_LG_REQS = bsg_safe_clog2(reqs_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [reqs_p-1:0]          req_v_i,
    input  logic [reqs_p*c_CNT_W-1:0]  req_amount_i,
    output logic [reqs_p-1:0]          req_yumi_o,
    output logic [c_LG_ELS-1:0]        grant_id_o,
    input  logic [c_CNT_W-1:0]         fifo_alloc_v_count_i,
    input  logic [c_LG_ELS-1:0]        fifo_alloc_id_i,
    output logic [c_CNT_W-1:0]         fifo_alloc_yumi_variable_o,
    output logic                       locked_o
`ifdef BSG_FIFO_REORDER_ALLOC_ARBITER_STATS_EN
    ,
    output logic [31:0]                stat_grants_o,
    output logic [31:0]                stat_slots_o,
    output logic [15:0]                stat_locks_o
`endif
);

    localparam int                    c_STARVE_W     = bsg_width(starve_limit_p);
    localparam logic [c_STARVE_W-1:0] c_STARVE_LIMIT = c_STARVE_W'(starve_limit_p);
    localparam logic [c_LG_REQS-1:0]  c_LAST_REQ     = c_LG_REQS'(reqs_p - 1);

    state_e                state_r,      w_state_n;
    logic [c_LG_REQS-1:0]  rr_ptr_r,     w_rr_ptr_n;
    logic [c_LG_REQS-1:0]  lock_id_r,    w_lock_id_n;
    logic [c_STARVE_W-1:0] starve_cnt_r, w_starve_cnt_n;

    logic [c_CNT_W-1:0]    w_amount [reqs_p];
    logic [reqs_p-1:0]     w_elig;
    logic [reqs_p-1:0]     w_lock_mask;
    logic [reqs_p-1:0]     w_grant_oh;
    logic [c_LG_REQS-1:0]  w_grant_idx;
    logic                  w_grant_v;
    logic [c_LG_REQS-1:0]  w_grant_next;
    logic                  w_head_v;
    logic                  w_head_elig;
    logic                  w_head_granted;

    // ------------------------------------------------------------------
    // Eligibility: request fits in the currently reported free space.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < reqs_p; i++) begin
            w_amount[i] = req_amount_i[i*c_CNT_W +: c_CNT_W];
            w_elig[i]   = req_v_i[i] && (w_amount[i] <= fifo_alloc_v_count_i);
        end
    end

    // While locked, only the latched owner may win.
    always_comb begin
        w_lock_mask = '1;
        if (state_r == e_lock) begin
            w_lock_mask            = '0;
            w_lock_mask[lock_id_r] = 1'b1;
        end
    end

    bsg_fifo_reorder_alloc_rr_pick #(
        .reqs_p (reqs_p)
    ) u_rr_pick (
        .i_elig      (w_elig),
        .i_rr_ptr    (rr_ptr_r),
        .i_lock_mask (w_lock_mask),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_grant_v   (w_grant_v)
    );

    // ------------------------------------------------------------------
    // Outputs: forced quiet while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        req_yumi_o                 = '0;
        fifo_alloc_yumi_variable_o = '0;
        locked_o                   = 1'b0;
        grant_id_o                 = fifo_alloc_id_i;
        if (!reset_i) begin
            req_yumi_o = w_grant_oh;
            locked_o   = (state_r == e_lock);
            if (w_grant_v) begin
                fifo_alloc_yumi_variable_o = w_amount[w_grant_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM, round-robin pointer and starvation counter.
    // ------------------------------------------------------------------
    assign w_grant_next   = (w_grant_idx == c_LAST_REQ) ? '0 : (w_grant_idx + c_LG_REQS'(1));
    assign w_head_v       = req_v_i[rr_ptr_r];
    assign w_head_elig    = w_elig[rr_ptr_r];
    assign w_head_granted = w_grant_v && (w_grant_idx == rr_ptr_r);

    always_comb begin
        w_state_n      = state_r;
        w_rr_ptr_n     = rr_ptr_r;
        w_lock_id_n    = lock_id_r;
        w_starve_cnt_n = starve_cnt_r;
        case (state_r)
            e_arb: begin
                if (w_grant_v) begin
                    w_rr_ptr_n = w_grant_next;
                end
                if (!w_head_v || w_head_granted) begin
                    w_starve_cnt_n = '0;
                end else if (!w_head_elig && (starve_cnt_r != '1)) begin
                    w_starve_cnt_n = starve_cnt_r + c_STARVE_W'(1);
                end
                // Owner is the head that starved, not wherever rr_ptr moves to.
                if (w_starve_cnt_n >= c_STARVE_LIMIT) begin
                    w_state_n   = e_lock;
                    w_lock_id_n = rr_ptr_r;
                end
            end
            e_lock: begin
                // Only lock_id_r can be granted here, so w_grant_next = lock_id_r+1.
                if (w_grant_v) begin
                    w_state_n      = e_arb;
                    w_rr_ptr_n     = w_grant_next;
                    w_starve_cnt_n = '0;
                end
            end
            default: begin
                w_state_n = e_arb;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= e_arb;
            rr_ptr_r     <= '0;
            lock_id_r    <= '0;
            starve_cnt_r <= '0;
        end else begin
            state_r      <= w_state_n;
            rr_ptr_r     <= w_rr_ptr_n;
            lock_id_r    <= w_lock_id_n;
            starve_cnt_r <= w_starve_cnt_n;
        end
    end

`ifdef BSG_FIFO_REORDER_ALLOC_ARBITER_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters.
    // ------------------------------------------------------------------
    logic [31:0] r_stat_grants;
    logic [31:0] r_stat_slots;
    logic [15:0] r_stat_locks;
    logic [32:0] w_slots_sum;

    assign w_slots_sum = {1'b0, r_stat_slots} + 33'(fifo_alloc_yumi_variable_o);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stat_grants <= '0;
            r_stat_slots  <= '0;
            r_stat_locks  <= '0;
        end else begin
            if (w_grant_v && (r_stat_grants != '1)) begin
                r_stat_grants <= r_stat_grants + 32'd1;
            end
            if (w_grant_v) begin
                r_stat_slots <= w_slots_sum[32] ? '1 : w_slots_sum[31:0];
            end
            if ((state_r == e_arb) && (w_state_n == e_lock) && (r_stat_locks != '1)) begin
                r_stat_locks <= r_stat_locks + 16'd1;
            end
        end
    end

    assign stat_grants_o = r_stat_grants;
    assign stat_slots_o  = r_stat_slots;
    assign stat_locks_o  = r_stat_locks;
`endif

`ifndef SYNTHESIS
    // ------------------------------------------------------------------
    // Protocol checks on the requester side.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < reqs_p; gi++) begin : g_req_assert
        a_hold_v : assert property (@(posedge clk_i) disable iff (reset_i)
            (req_v_i[gi] && !req_yumi_o[gi]) |=> req_v_i[gi]);
        a_hold_amount : assert property (@(posedge clk_i) disable iff (reset_i)
            (req_v_i[gi] && !req_yumi_o[gi]) |=> $stable(req_amount_i[gi*c_CNT_W +: c_CNT_W]));
        a_amount_range : assert property (@(posedge clk_i) disable iff (reset_i)
            req_v_i[gi] |-> (req_amount_i[gi*c_CNT_W +: c_CNT_W] <= c_CNT_W'(els_p)));
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_fifo_reorder_alloc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_fifo_reorder_alloc_arbiter
//  Description : Scoreboard bench for bsg_fifo_reorder_alloc_arbiter
//                (reqs_p=4, els_p=16, starve_limit_p=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_fifo_reorder_alloc_arbiter;

    localparam int c_REQS  = 4;
    localparam int c_ELS   = 16;
    localparam int c_CNT_W = 5;
    localparam int c_LG_EL = 4;

    logic                      clk;
    logic                      reset_i;
    logic [c_REQS-1:0]         req_v_i;
    logic [c_REQS*c_CNT_W-1:0] req_amount_i;
    logic [c_REQS-1:0]         req_yumi_o;
    logic [c_LG_EL-1:0]        grant_id_o;
    logic [c_CNT_W-1:0]        fifo_alloc_v_count_i;
    logic [c_LG_EL-1:0]        fifo_alloc_id_i;
    logic [c_CNT_W-1:0]        fifo_alloc_yumi_variable_o;
    logic                      locked_o;
`ifdef BSG_FIFO_REORDER_ALLOC_ARBITER_STATS_EN
    logic [31:0]               stat_grants;
    logic [31:0]               stat_slots;
    logic [15:0]               stat_locks;
`endif

    bsg_fifo_reorder_alloc_arbiter #(
        .reqs_p         (c_REQS),
        .els_p          (c_ELS),
        .starve_limit_p (8)
    ) dut (
        .clk_i                      (clk),
        .reset_i                    (reset_i),
        .req_v_i                    (req_v_i),
        .req_amount_i               (req_amount_i),
        .req_yumi_o                 (req_yumi_o),
        .grant_id_o                 (grant_id_o),
        .fifo_alloc_v_count_i       (fifo_alloc_v_count_i),
        .fifo_alloc_id_i            (fifo_alloc_id_i),
        .fifo_alloc_yumi_variable_o (fifo_alloc_yumi_variable_o),
        .locked_o                   (locked_o)
`ifdef BSG_FIFO_REORDER_ALLOC_ARBITER_STATS_EN
        ,
        .stat_grants_o              (stat_grants),
        .stat_slots_o               (stat_slots),
        .stat_locks_o               (stat_locks)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int k;
        int amt;
        int id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   left [c_REQS];
    logic smp_locked;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Requester k asks for amt slots, n times back to back.
    task automatic set_req(input int k, input int amt, input int n);
        req_amount_i[k*c_CNT_W +: c_CNT_W] = c_CNT_W'(amt);
        left[k]    = n;
        req_v_i[k] = (n > 0);
    endtask

    task automatic push_exp(input int k, input int amt, input int id);
        exp_t e;
        e.k   = k;
        e.amt = amt;
        e.id  = id;
        sb.push_back(e);
    endtask

    // One clock: sample at the falling edge, retire granted requests after
    // the rising edge.
    task automatic do_cycle();
        logic [c_REQS-1:0] got;
        exp_t e;
        got = '0;
        @(negedge clk);
        smp_locked = locked_o;
        if (reset_i) begin
            check_eq("rst_yumi", 32'(req_yumi_o), 32'd0);
            check_eq("rst_amount", 32'(fifo_alloc_yumi_variable_o), 32'd0);
            check_eq("rst_locked", 32'(locked_o), 32'd0);
        end else if (req_yumi_o != '0) begin
            got = req_yumi_o;
            if (sb.size() == 0) begin
                check_eq("unexpected_yumi", 32'(req_yumi_o), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("yumi", 32'(req_yumi_o), 32'd1 << e.k);
                check_eq("amount", 32'(fifo_alloc_yumi_variable_o), 32'(e.amt));
                check_eq("grant_id", 32'(grant_id_o), 32'(e.id));
            end
        end else begin
            check_eq("idle_amount", 32'(fifo_alloc_yumi_variable_o), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < c_REQS; i++) begin
            if (got[i]) begin
                left[i]--;
                if (left[i] <= 0) req_v_i[i] = 1'b0;
            end
        end
    endtask

    // Run until every expected grant has been seen, within n cycles.
    task automatic run_until_empty(input int n);
        for (int c = 0; (c < n) && (sb.size() > 0); c++) begin
            do_cycle();
        end
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i              = 1'b1;
        req_v_i              = '0;
        req_amount_i         = '0;
        fifo_alloc_v_count_i = 5'd16;
        fifo_alloc_id_i      = 4'd3;
        smp_locked           = 1'b0;
        set_req(0, 1, 2);
        set_req(1, 1, 1);
        set_req(2, 1, 1);
        set_req(3, 1, 1);

        // Reset with all requests up: outputs stay quiet.
        repeat (3) do_cycle();
        reset_i = 1'b0;

        // Round robin from requester 0.
        push_exp(0, 1, 3);
        push_exp(1, 1, 3);
        push_exp(2, 1, 3);
        push_exp(3, 1, 3);
        push_exp(0, 1, 3);
        run_until_empty(5);
        do_cycle();
        check_eq("rr_locked", 32'(smp_locked), 32'd0);

        // Exact fit (rr_ptr=1): req1 blocked until free reaches 6.
        fifo_alloc_v_count_i = 5'd5;
        fifo_alloc_id_i      = 4'd15;
        set_req(0, 5, 1);
        set_req(1, 6, 1);
        push_exp(0, 5, 15);
        run_until_empty(1);
        repeat (2) do_cycle();
        fifo_alloc_v_count_i = 5'd6;
        push_exp(1, 6, 15);
        run_until_empty(1);

        // Zero amount with no free space (rr_ptr=2).
        fifo_alloc_v_count_i = 5'd0;
        fifo_alloc_id_i      = 4'd0;
        set_req(2, 0, 1);
        set_req(0, 1, 1);
        push_exp(2, 0, 0);
        run_until_empty(1);
        do_cycle();
        fifo_alloc_v_count_i = 5'd1;
        push_exp(0, 1, 0);
        run_until_empty(1);

        // Starvation (rr_ptr=1): req3's grants keep head at 0; req0 starves.
        fifo_alloc_v_count_i = 5'd3;
        fifo_alloc_id_i      = 4'd9;
        set_req(0, 8, 1);
        set_req(3, 1, 10);
        for (int i = 0; i < 9; i++) push_exp(3, 1, 9);
        run_until_empty(9);
        check_eq("pre_lock", 32'(smp_locked), 32'd0);
        set_req(1, 1, 1);
        set_req(2, 1, 1);
        repeat (3) begin
            do_cycle();
            check_eq("locked", 32'(smp_locked), 32'd1);
        end
        fifo_alloc_v_count_i = 5'd8;
        push_exp(0, 8, 9);
        run_until_empty(1);
        check_eq("locked_at_release", 32'(smp_locked), 32'd1);
        push_exp(1, 1, 9);
        run_until_empty(1);
        check_eq("unlocked", 32'(smp_locked), 32'd0);
        push_exp(2, 1, 9);
        push_exp(3, 1, 9);
        run_until_empty(2);

        // Lock again (rr_ptr=0), then reset while locked.
        fifo_alloc_v_count_i = 5'd3;
        fifo_alloc_id_i      = 4'd5;
        set_req(0, 8, 1);
        repeat (8) do_cycle();
        do_cycle();
        check_eq("lock2_on", 32'(smp_locked), 32'd1);
        reset_i = 1'b1;
        do_cycle();
        reset_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_cycle();
            check_eq("post_rst_unlocked", 32'(smp_locked), 32'd0);
        end
        do_cycle();
        check_eq("relock", 32'(smp_locked), 32'd1);
        fifo_alloc_v_count_i = 5'd8;
        push_exp(0, 8, 5);
        run_until_empty(1);
        do_cycle();
        check_eq("final_unlocked", 32'(smp_locked), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
